fifo_rd_packer: RTL and testbench

// - Read-side consumer of the FIFO_TOP read port, clocked in the read domain.
// - Pops DATA_WIDTH words whenever rempty=0 and packs PACK_N of them, LSB lane first, into one output word.
// - Output is valid/ready; a back-pressured output stalls FIFO pops and never drops data.

---
 rtl/fifo_rd_pkg.sv | 30 +++
 rtl/fifo_rd_tmo.sv | 33 +++
 rtl/fifo_rd_packer.sv | 138 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and width helpers for the FIFO read-side packer.
// Defaults match an 8-bit FIFO packed four words at a time with a 16-cycle idle timeout.
package fifo_rd_pkg;

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PACK_N_DEF     = 4;
    localparam int TIMEOUT_DEF    = 16;

    function automatic int idx_w(input int pack_n);
        return (pack_n > 1) ? $clog2(pack_n) : 1;
    endfunction

    function automatic int cnt_w(input int pack_n);
        return $clog2(pack_n + 1);
    endfunction

    function automatic int tmo_w(input int timeout);
        return (timeout > 1) ? $clog2(timeout + 1) : 1;
    endfunction

    localparam int IDX_W = idx_w(PACK_N_DEF);
    localparam int CNT_W = cnt_w(PACK_N_DEF);
    localparam int TMO_W = tmo_w(TIMEOUT_DEF);

endpackage

// File: rtl/fifo_rd_tmo.sv
// Idle timeout counter for the read packer; used only when RD_TIMEOUT_EN is defined.
// tc is asserted on the enabled edge where the count has reached TIMEOUT-1.
module fifo_rd_tmo
    import fifo_rd_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int TW = tmo_w(TIMEOUT);
    localparam logic [TW-1:0] TERM = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_r;

    assign tc = en && (cnt_r == TERM);

    // Count idle edges, saturating at the terminal value until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && !tc) begin
            cnt_r <= cnt_r + TW'(1);
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO words and packs PACK_N of them, lane 0 first, into a valid/ready output word.
// Optional partial-word flush after an idle timeout is enabled by defining RD_TIMEOUT_EN.
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PACK_N     = PACK_N_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                               r_clk,
    input  logic                               rrst_n,
    input  logic [DATA_WIDTH-1:0]              r_data,
    input  logic                               rempty,
    output logic                               r_inc,
    output logic [PACK_N*DATA_WIDTH-1:0]       out_data,
    output logic [$clog2(PACK_N+1)-1:0]        out_cnt,
    output logic                               out_valid,
    input  logic                               out_ready
);

    localparam int IW = idx_w(PACK_N);
    localparam int CW = cnt_w(PACK_N);
    localparam int OW = PACK_N * DATA_WIDTH;
    localparam logic [IW-1:0] LAST_IDX = IW'(PACK_N - 1);

    if (PACK_N < 2) begin : g_bad_pack_n
        $error("fifo_rd_packer: PACK_N must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fifo_rd_packer: TIMEOUT must be at least 1");
    end

    logic [OW-1:0] pack_r;
    logic [OW-1:0] pack_ins_s;
    logic [IW-1:0] idx_r;
    logic          out_free_s;
    logic          last_lane_s;
    logic          handshake_s;
    logic          pop_gate_s;
    logic          pop_s;
    logic          complete_s;
    logic          flush_s;

    assign out_free_s  = !out_valid || out_ready;
    assign last_lane_s = (idx_r == LAST_IDX);
    assign handshake_s = out_valid && out_ready;

`ifdef RD_TIMEOUT_EN
    state_t state_r;
    logic   tmo_en_s;
    logic   tmo_clr_s;
    logic   tmo_tc_s;

    assign pop_gate_s = (state_r == S_FILL);
    assign flush_s    = (state_r == S_FLUSH) && out_free_s;
    assign tmo_en_s   = (state_r == S_FILL) && (idx_r != {IW{1'b0}}) && rempty;
    assign tmo_clr_s  = pop_s || flush_s;

    fifo_rd_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk   (r_clk),
        .rst_n (rrst_n),
        .clr   (tmo_clr_s),
        .en    (tmo_en_s),
        .tc    (tmo_tc_s)
    );

    // Fill/flush sequencing: a timed-out partial word waits for the out reg to free up.
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_r <= S_FILL;
        end else begin
            case (state_r)
                S_FILL: begin
                    if (tmo_tc_s) begin
                        state_r <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (out_free_s) begin
                        state_r <= S_FILL;
                    end
                end
                default: begin
                    state_r <= S_FILL;
                end
            endcase
        end
    end
`else
    assign pop_gate_s = 1'b1;
    assign flush_s    = 1'b0;
`endif

    // The last lane may only be popped when the out reg can take the completed word.
    assign pop_s      = rrst_n && !rempty && pop_gate_s && !(last_lane_s && !out_free_s);
    assign r_inc      = pop_s;
    assign complete_s = pop_s && last_lane_s;

    // Pack contents with the incoming FIFO word dropped into lane idx.
    always_comb begin
        pack_ins_s = pack_r;
        pack_ins_s[idx_r*DATA_WIDTH +: DATA_WIDTH] = r_data;
    end

    // Pack reg, lane index and out reg; completion and flush override the handshake clear.
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            pack_r    <= '0;
            idx_r     <= '0;
            out_data  <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
        end else if (complete_s) begin
            out_data  <= pack_ins_s;
            out_cnt   <= CW'(PACK_N);
            out_valid <= 1'b1;
            pack_r    <= '0;
            idx_r     <= '0;
        end else if (flush_s) begin
            out_data  <= pack_r;
            out_cnt   <= CW'(idx_r);
            out_valid <= 1'b1;
            pack_r    <= '0;
            idx_r     <= '0;
        end else begin
            if (pop_s) begin
                pack_r <= pack_ins_s;
                idx_r  <= idx_r + IW'(1);
            end
            if (handshake_s) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Randomized, model-checked bench for fifo_rd_packer (default build, no timeout flush).
// A queue-based model of the FIFO and packer is compared against the DUT every cycle.
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int PN = 4;
    localparam int TMO = 16;

    logic        r_clk = 1'b0;
    logic        rrst_n = 1'b0;
    logic [7:0]  r_data = 8'h00;
    logic        rempty = 1'b1;
    logic        r_inc;
    logic [31:0] out_data;
    logic [2:0]  out_cnt;
    logic        out_valid;
    logic        out_ready = 1'b0;

    fifo_rd_packer #(
        .DATA_WIDTH (DW),
        .PACK_N     (PN),
        .TIMEOUT    (TMO)
    ) dut (
        .r_clk     (r_clk),
        .rrst_n    (rrst_n),
        .r_data    (r_data),
        .rempty    (rempty),
        .r_inc     (r_inc),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 r_clk = ~r_clk;

    int checks = 0;
    int errors = 0;

    byte unsigned fifo_q[$];
    byte unsigned part_q[$];
    logic [31:0]  got_q[$];
    logic         m_valid;
    logic [31:0]  m_data;
    logic [2:0]   m_cnt;
    int           pops;
    bit           hold_empty;
    bit           rdy;
    int           pushed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        part_q.delete();
        m_valid = 1'b0;
        m_data  = 32'h0;
        m_cnt   = 3'd0;
    endtask

    // One clock: drive inputs at the falling edge, compare, then advance the model past the rising edge.
    task automatic cycle();
        logic exp_inc;
        if (!rrst_n) model_reset();
        rempty    = hold_empty || (fifo_q.size() == 0);
        r_data    = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        out_ready = rdy;
        #1;
        exp_inc = rrst_n && !rempty && !(part_q.size() == PN-1 && m_valid && !rdy);
        chk("r_inc", {31'd0, r_inc}, {31'd0, exp_inc});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_data", out_data, m_data);
        chk("out_cnt", {29'd0, out_cnt}, {29'd0, m_cnt});
        if (rrst_n) begin
            if (m_valid && rdy) begin
                got_q.push_back(m_data);
                m_valid = 1'b0;
            end
            if (exp_inc) begin
                pops++;
                part_q.push_back(fifo_q.pop_front());
                if (part_q.size() == PN) begin
                    m_data  = {part_q[3], part_q[2], part_q[1], part_q[0]};
                    m_cnt   = 3'(PN);
                    m_valid = 1'b1;
                    part_q.delete();
                end
            end
        end
        @(negedge r_clk);
    endtask

    task automatic push_seq(input int first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(8'(first + i));
    endtask

    initial begin
        int n;
        model_reset();
        hold_empty = 1'b0;
        rdy = 1'b1;
        pops = 0;
        @(negedge r_clk);

        // Reset held with data waiting: nothing popped, outputs zero.
        push_seq(1, 8);
        for (int i = 0; i < 3; i++) cycle();
        chk("rst_pops", 32'(pops), 32'd0);

        // Stream 01..08 with out_ready high: eight back-to-back pops.
        rrst_n = 1'b1;
        n = 0;
        while (fifo_q.size() > 0 && n < 50) begin
            cycle();
            n++;
        end
        chk("stream_cycles", 32'(n), 32'd8);
        chk("stream_pops", 32'(pops), 32'd8);
        cycle();
        cycle();
        chk("stream_words", 32'(got_q.size()), 32'd2);
        chk("stream_w0", got_q[0], 32'h04030201);
        chk("stream_w1", got_q[1], 32'h08070605);

        // Back-pressure: 12 words with out_ready low.
        got_q.delete();
        pops = 0;
        rdy = 1'b0;
        push_seq(1, 12);
        for (int i = 0; i < 10; i++) cycle();
        chk("bp_pops", 32'(pops), 32'd7);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_data", out_data, 32'h04030201);
        chk("bp_cnt", {29'd0, out_cnt}, 32'd4);
        rdy = 1'b1;
        cycle();
        chk("dwc_valid", {31'd0, out_valid}, 32'd1);
        chk("dwc_data", out_data, 32'h08070605);
        for (int i = 0; i < 10; i++) cycle();
        chk("bp_words", 32'(got_q.size()), 32'd3);
        chk("bp_w0", got_q[0], 32'h04030201);
        chk("bp_w1", got_q[1], 32'h08070605);
        chk("bp_w2", got_q[2], 32'h0C0B0A09);

        // Empty gap: partial lanes wait indefinitely.
        got_q.delete();
        pops = 0;
        push_seq(1, 2);
        for (int i = 0; i < 42; i++) cycle();
        chk("gap_valid", {31'd0, out_valid}, 32'd0);
        chk("gap_pops", 32'(pops), 32'd2);
        push_seq(3, 2);
        for (int i = 0; i < 4; i++) cycle();
        chk("gap_words", 32'(got_q.size()), 32'd1);
        chk("gap_w0", got_q[0], 32'h04030201);

        // Reset mid-word discards the partial lanes.
        got_q.delete();
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        cycle();
        cycle();
        rrst_n = 1'b0;
        cycle();
        cycle();
        push_seq(8'h0A, 4);
        rrst_n = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("mid_words", 32'(got_q.size()), 32'd1);
        chk("mid_w0", got_q[0], 32'h0D0C0B0A);

        // Random traffic: pushes, empty gaps and back-pressure.
        got_q.delete();
        pushed = 0;
        for (int i = 0; i < 3000; i++) begin
            int k;
            k = (fifo_q.size() < 16) ? $urandom_range(2, 0) : 0;
            for (int j = 0; j < k; j++) begin
                fifo_q.push_back(8'($urandom));
                pushed++;
            end
            hold_empty = ($urandom_range(4, 0) == 0);
            rdy = ($urandom_range(9, 0) < 6);
            cycle();
        end
        hold_empty = 1'b0;
        rdy = 1'b1;
        n = 0;
        while ((fifo_q.size() > 0 || m_valid) && n < 200) begin
            cycle();
            n++;
        end
        chk("rand_drained", {31'd0, out_valid}, 32'd0);
        chk("rand_count", 32'(got_q.size() * PN + part_q.size()), 32'(pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
